// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit words and streams them
// through a small FIFO to the instruction-memory write port with sequential addresses.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_kind,
  input  logic [4:0]               req_rs,
  input  logic [4:0]               req_rt,
  input  logic [4:0]               req_rd,
  input  logic [15:0]              req_imm,
  input  logic [25:0]              req_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    K_ADD  = 3'd0,
    K_LW   = 3'd1,
    K_SW   = 3'd2,
    K_BEQ  = 3'd3,
    K_J    = 3'd4,
    K_ADDI = 3'd5,
    K_ANDI = 3'd6,
    K_ORI  = 3'd7
  } kind_e;

  kind_e             kind;
  logic [31:0]       enc_word;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [ADDR_W-1:0] addr_q;
  logic              push;
  logic              pop;

  assign kind = kind_e'(req_kind);

  always_comb begin
    enc_word = '0;
    case (kind)
      K_ADD:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      K_LW:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
      K_SW:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
      K_BEQ:   enc_word = {6'b000100, req_rs, req_rt, req_imm};
      K_J:     enc_word = {6'b000010, req_target};
      K_ADDI:  enc_word = {6'b001000, req_rs, req_rt, req_imm};
      K_ANDI:  enc_word = {6'b001100, req_rs, req_rt, req_imm};
      K_ORI:   enc_word = {6'b001101, req_rs, req_rt, req_imm};
      default: enc_word = '0;
    endcase
  end

  // Readiness depends only on registered occupancy, never on out_ready.
  assign req_ready = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = req_valid && req_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rptr_q];
  assign out_addr  = addr_q;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= enc_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule
